instr_fetch_unit: RTL and testbench

- Producer side of the opcode interface that feeds Control.
- Holds the program counter (PC) and fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Latches each word into the instruction register (IR) and presents its opcode field to Control with a valid/done handshake.
- Applies the next-PC update (sequential or jump) when the downstream stage retires the instruction.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/fetch_watchdog.sv | 27 ++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, opcode field bounds and the
// fetch-unit state encoding.
package cpu_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int OPC_W  = OPC_HI - OPC_LO + 1;

    localparam logic [OPC_W-1:0] OP_ADD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LOAD  = 5'b10110;
    localparam logic [OPC_W-1:0] OP_STORE = 5'b10111;
    localparam logic [OPC_W-1:0] OP_JMP   = 5'b11000;
    localparam logic [OPC_W-1:0] OP_BEQ   = 5'b11001;
    localparam logic [OPC_W-1:0] OP_HALT  = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_HALT,
        ST_ERR
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts FETCH cycles without an ack and flags expiry on the last allowed one.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fetching,
    input  logic ack,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the ack-less FETCH cycles already completed; it sits at zero
    // outside FETCH so every new fetch starts from a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (!fetching)  cnt <= '0;
        else if (!ack)       cnt <= cnt + 1'b1;
    end

    // The current cycle would make the count reach TIMEOUT_CYC; an ack wins.
    assign expired = fetching && !ack && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, IR and the fetch/hold/halt sequencing feeding Control.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              PC_STEP     = 4,
    parameter int              TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [4:0]      opcode,
    output logic [PC_W-1:0] pc,
    input  logic            instr_done,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    output logic            halted,
    output logic            fetch_err
);
    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     ir_q;
    logic            wd_expired;

    wire fetching = (state_q == ST_FETCH);
    wire ack_take = fetching && imem_ack;
    wire retire   = (state_q == ST_HOLD) && instr_done;

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetching (fetching),
        .ack      (imem_ack),
        .expired  (wd_expired)
    );
    assign fetch_err = (state_q == ST_ERR);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign wd_expired     = 1'b0;
    assign fetch_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack)
                    state_d = (opcode_of(imem_rdata) == OP_HALT) ? ST_HALT : ST_HOLD;
                else if (wd_expired)
                    state_d = ST_ERR;
            end
            ST_HOLD:  if (instr_done) state_d = run ? ST_FETCH : ST_IDLE;
            ST_HALT:  state_d = ST_HALT;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // PC only moves at retire, so it names the IR's instruction throughout HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            ir_q <= '0;
        end else begin
            if (ack_take) ir_q <= imem_rdata;
            if (retire)   pc_q <= jump ? jump_target : pc_q + PC_W'(PC_STEP);
        end
    end

    assign imem_req    = fetching;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_HOLD);
    assign instr       = ir_q;
    assign opcode      = opcode_of(ir_q);
    assign pc          = pc_q;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_done = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        imem_req, instr_valid, halted, fetch_err;
    logic [31:0] imem_addr, instr, pc;
    logic [4:0]  opcode;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .pc(pc),
        .instr_done(instr_done), .jump(jump), .jump_target(jump_target),
        .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TIMEOUT = 16;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the unit is doing, expressed as an activity plus the
    // architectural PC and IR values the rules say it must hold.
    localparam int M_IDLE = 0, M_WAIT_WORD = 1, M_EXEC = 2, M_HALTED = 3, M_FAULT = 4;
    int          m_mode;
    int          m_wait_cycles;
    logic [31:0] m_pc, m_ir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_pc = 32'h0; m_ir = 32'h0; m_wait_cycles = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (run) begin m_mode = M_WAIT_WORD; m_wait_cycles = 0; end
                M_WAIT_WORD: begin
                    m_wait_cycles = m_wait_cycles + 1;
                    if (imem_ack) begin
                        m_ir = imem_rdata;
                        m_mode = (imem_rdata[31:27] == 5'd31) ? M_HALTED : M_EXEC;
                    end else if (TO_EN && m_wait_cycles >= TIMEOUT) begin
                        m_mode = M_FAULT;
                    end
                end
                M_EXEC: if (instr_done) begin
                    m_pc = jump ? jump_target : m_pc + 32'd4;
                    m_mode = run ? M_WAIT_WORD : M_IDLE;
                    m_wait_cycles = 0;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("m_imem_req",    64'(imem_req),    64'(m_mode == M_WAIT_WORD));
            chk("m_imem_addr",   64'(imem_addr),   64'(m_pc));
            chk("m_instr_valid", 64'(instr_valid), 64'(m_mode == M_EXEC));
            chk("m_instr",       64'(instr),       64'(m_ir));
            chk("m_opcode",      64'(opcode),      64'(m_ir >> 27));
            chk("m_pc",          64'(pc),          64'(m_pc));
            chk("m_halted",      64'(halted),      64'(m_mode == M_HALTED));
            chk("m_fetch_err",   64'(fetch_err),   64'(m_mode == M_FAULT));
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    logic [4:0] ops [7];
    int stuck;

    initial begin
        ops = '{5'b00000, 5'b00010, 5'b10110, 5'b10111, 5'b11000, 5'b11001, 5'b11111};
        cyc(2);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        cmp_en = 1'b1;

        // Sequential flow, everything immediate
        rst_n = 1'b1; run = 1'b1; imem_ack = 1'b1; instr_done = 1'b1; imem_rdata = 32'h0;
        cyc(); chk("seq_addr0", 64'(imem_addr), 64'h0); chk("seq_req0", 64'(imem_req), 64'd1);
        cyc(); chk("seq_valid0", 64'(instr_valid), 64'd1); chk("seq_req_off", 64'(imem_req), 64'd0);
        chk("seq_opc", 64'(opcode), 64'd0);
        cyc(); chk("seq_addr4", 64'(imem_addr), 64'h4); chk("seq_valid_off", 64'(instr_valid), 64'd0);
        cyc(); chk("seq_valid1", 64'(instr_valid), 64'd1);
        cyc(); chk("seq_addr8", 64'(imem_addr), 64'h8); chk("seq_req2", 64'(imem_req), 64'd1);

        // Reset in the middle of a fetch
        #2 rst_n = 1'b0;
        #1 chk("rstmid_req", 64'(imem_req), 64'd0); chk("rstmid_pc", 64'(pc), 64'h0);
        cyc(); rst_n = 1'b1;

        // Jump from PC=4
        cyc(); chk("j_addr0", 64'(imem_addr), 64'h0);
        cyc(); cyc(); chk("j_addr4", 64'(imem_addr), 64'h4);
        imem_rdata = 32'hC000_0000; instr_done = 1'b0; jump = 1'b1; jump_target = 32'h40;
        cyc(); chk("j_opc", 64'(opcode), 64'b11000); chk("j_pc", 64'(pc), 64'h4);
        cyc(); chk("j_nodone_pc", 64'(pc), 64'h4); chk("j_nodone_valid", 64'(instr_valid), 64'd1);
        instr_done = 1'b1;
        cyc(); chk("j_addr40", 64'(imem_addr), 64'h40); chk("j_req", 64'(imem_req), 64'd1);

        // Memory wait states: ack arrives on the 4th request cycle
        jump = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h1234_5678;
        for (int i = 2; i <= 4; i++) begin
            cyc(); chk("ws_req", 64'(imem_req), 64'd1); chk("ws_addr", 64'(imem_addr), 64'h40);
            chk("ws_valid", 64'(instr_valid), 64'd0);
        end
        imem_ack = 1'b1;
        cyc(); chk("ws_valid", 64'(instr_valid), 64'd1); chk("ws_instr", 64'(instr), 64'h1234_5678);
        chk("ws_opc", 64'(opcode), 64'b00010);

        // Stop: run low in HOLD retires then idles with PC advanced
        run = 1'b0;
        cyc(); chk("stop_req", 64'(imem_req), 64'd0); chk("stop_valid", 64'(instr_valid), 64'd0);
        chk("stop_pc", 64'(pc), 64'h44);
        cyc(); chk("stop_idle", 64'(imem_req), 64'd0);

        // Halt
        run = 1'b1; imem_rdata = 32'hF800_0000;
        cyc(); chk("h_addr", 64'(imem_addr), 64'h44);
        for (int i = 0; i < 4; i++) begin
            cyc(); chk("h_halted", 64'(halted), 64'd1); chk("h_req", 64'(imem_req), 64'd0);
            chk("h_valid", 64'(instr_valid), 64'd0);
        end

        // Randomized traffic against the model
        do_reset();
        stuck = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            run         = ($urandom_range(7) != 0);
            imem_ack    = ($urandom_range(2) == 0);
            imem_rdata  = {(($urandom_range(39) == 0) ? ops[6] : ops[$urandom_range(5)]),
                           27'($urandom)};
            instr_done  = $urandom_range(1);
            jump        = ($urandom_range(3) == 0);
            jump_target = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            if (m_mode == M_HALTED || m_mode == M_FAULT) stuck++;
            if (stuck > 3 || $urandom_range(399) == 0) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
                stuck = 0;
            end
        end

        if (TO_EN) begin
            // Watchdog: never ack
            do_reset();
            run = 1'b1; imem_ack = 1'b0; instr_done = 1'b0; jump = 1'b0;
            cyc(); chk("to_req1", 64'(imem_req), 64'd1);
            cyc(15); chk("to_req16", 64'(imem_req), 64'd1); chk("to_err16", 64'(fetch_err), 64'd0);
            cyc(); chk("to_err", 64'(fetch_err), 64'd1); chk("to_req_off", 64'(imem_req), 64'd0);
            imem_ack = 1'b1;
            cyc(3); chk("to_sticky", 64'(fetch_err), 64'd1);
            // Ack exactly on the 16th cycle
            do_reset();
            imem_ack = 1'b0; imem_rdata = 32'h0;
            cyc(); cyc(15);
            imem_ack = 1'b1;
            cyc(); chk("to_ack16_err", 64'(fetch_err), 64'd0); chk("to_ack16_valid", 64'(instr_valid), 64'd1);
        end

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
